branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side counterpart to the EX-stage branch comparator.
- Predicts direction and target for the PC being fetched, using a direct-mapped table of 2-bit saturating counters plus a BTB.
- Takes the resolved outcome back from EX, updates the tables, and flags mispredictions with the correct redirect PC so the pipeline can flush.
- Sits between the IF PC mux and the EX branch resolution path of the RV32I core.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, table entries; must be a power of two, minimum 2.
- IDX_W, log2(ENTRIES), index width (derived localparam).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  PC being fetched this cycle.
- pred_taken  out  1  prediction for if_pc, 1 = taken.
- pred_target  out  XLEN  next PC: BTB target if predicted taken, else if_pc+4.
- ex_valid  in  1  a conditional branch resolves in EX this cycle (Branch asserted).
- ex_pc  in  XLEN  PC of the resolving branch.
- ex_taken  in  1  resolved direction from the comparator result.
- ex_target  in  XLEN  computed branch target (ex_pc + B-immediate).
- ex_pred_taken  in  1  prediction made for this branch at fetch, piped down.
- ex_pred_target  in  XLEN  predicted next PC, piped down.
- mispredict  out  1  flush request for IF/ID.
- redirect_pc  out  XLEN  correct next PC when mispredict=1.
- br_count  out  32  resolved branches since reset.
- mp_count  out  32  mispredictions since reset.

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN-1:0], ctr[1:0].
  - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup (combinational, 0-cycle):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, modulo 2^XLEN.
- Update (on the rising edge of clk when ex_valid=1):
  - Hit, ex_taken=1: ctr = min(ctr+1, 11); target = ex_target.
  - Hit, ex_taken=0: ctr = max(ctr-1, 00); target unchanged.
  - Miss, ex_taken=1: allocate (overwrite) with valid=1, tag, target=ex_target, ctr=10.
  - Miss, ex_taken=0: no table write.
  - Only one entry is written per cycle; all other entries hold.
- Mispredict (combinational from EX inputs):
  - mispredict = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4. It is valid only while mispredict=1, but is always driven.
  - mispredict is 0 whenever ex_valid=0, regardless of other inputs.
- Statistics, registered:
  - br_count increments on each ex_valid cycle.
  - mp_count increments on each mispredict cycle.
  - Both wrap modulo 2^32.
- Simultaneous lookup and update of the same idx: the lookup returns pre-update contents. The write takes effect from the next cycle, with no bypass.
- Reset (asynchronous assert, released synchronously by the integration):
  - All valid=0, all ctr=01, targets=0, both stat counters=0.
  - Immediately after reset, pred_taken=0 and pred_target=if_pc+4 for every PC.
  - Reset asserted mid-update discards that update.
- No stall input: the block is always ready, and a resolving branch is presented to it exactly once.

Decomposition:
- Package branch_pkg holds:
  - counter state constants SNT/WNT/WT/ST;
  - the funct3 branch codes shared with the comparator (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111);
  - a saturating-update function sat2(ctr, taken).
- One sub-module, branch_btb_array: register array with one combinational read port, one synchronous write port and asynchronous clear. It holds valid/tag/target/ctr.
- The top level holds the mispredict logic and the statistics counters.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, br_count=0, mp_count=0.
- ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x80, mp_count=1.
- Four taken resolutions of 0x100 then three not-taken -> ctr sequence 10,11,11,11,10,01,00; prediction flips to not-taken after the 2nd not-taken.
- Aliasing (ENTRIES=16): 0x100 is taken and allocated; 0x140 then looked up -> miss, predicts 0x144. ex_taken=1 at 0x140 overwrites the entry; 0x100 then misses.
- Same-cycle lookup and update of 0x200 (first taken resolution) -> that cycle pred_taken=0; next cycle pred_taken=1.
- Taken branch predicted taken to a wrong target (pred 0x300, actual 0x400) -> mispredict=1, redirect_pc=0x400, target updated. ex_valid=0 with mismatching inputs -> mispredict=0 and no counter change.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch constants and saturating counter helper
package branch_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // funct3 encodings shared with the EX-stage comparator
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_e;

    function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            r = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and EX resolution signals of the predictor
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
    );
endinterface

// File: rtl/branch_btb_array.sv
// rtl/branch_btb_array.sv - direct-mapped valid/tag/target/counter table with lookup and update ports
module branch_btb_array #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [1:0]       rd_ctr,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);
    import branch_pkg::*;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic               wr_hit;

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Read-modify-write of the resolving entry; lookups see the old value this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= sat2(ctr_q[wr_idx], wr_taken);
                if (wr_taken) begin
                    target_q[wr_idx] <= wr_target;
                end
            end else if (wr_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
                ctr_q[wr_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal direction predictor with BTB, mispredict detect and stats
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);
    import branch_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic            rd_hit;
    logic [1:0]      rd_ctr;
    logic [XLEN-1:0] rd_target;
    logic            pred_taken;
    logic            mispredict;
    logic [31:0]     br_count_q;
    logic [31:0]     mp_count_q;

    branch_btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (bus.if_pc[IDX_W+1:2]),
        .rd_tag    (bus.if_pc[XLEN-1:IDX_W+2]),
        .rd_hit    (rd_hit),
        .rd_ctr    (rd_ctr),
        .rd_target (rd_target),
        .wr_en     (bus.ex_valid),
        .wr_idx    (bus.ex_pc[IDX_W+1:2]),
        .wr_tag    (bus.ex_pc[XLEN-1:IDX_W+2]),
        .wr_taken  (bus.ex_taken),
        .wr_target (bus.ex_target)
    );

    assign pred_taken      = rd_hit && rd_ctr[1];
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_taken ? rd_target : bus.if_pc + XLEN'(4);

    // A correct not-taken prediction never compares targets
    assign mispredict = bus.ex_valid &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            if (bus.ex_valid) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict) begin
                mp_count_q <= mp_count_q + 32'd1;
            end
        end
    end

    assign bus.br_count = br_count_q;
    assign bus.mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bus ();

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    bit   [0:5]  seq_taken = 6'b111000;
    bit   [0:5]  seq_pred  = 6'b111110;
    bit   [0:5]  seq_after = 6'b111100;
    logic [1:0]  seq_ctr [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_ptaken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return bus.ex_valid && ((bus.ex_taken != bus.ex_pred_taken) ||
                                (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    endfunction

    function automatic logic [31:0] m_redirect();
        return bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_update
        int i;
        if (!rst_n) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k]  <= 1'b0;
                m_tag[k]    <= 32'd0;
                m_target[k] <= 32'd0;
                m_cnt[k]    <= 1;
            end
            m_br <= 32'd0;
            m_mp <= 32'd0;
        end else if (bus.ex_valid) begin
            i = m_idx(bus.ex_pc);
            m_br <= m_br + 32'd1;
            if (m_mispredict()) m_mp <= m_mp + 32'd1;
            if (m_hit(bus.ex_pc)) begin
                if (bus.ex_taken) begin
                    m_cnt[i]    <= (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                    m_target[i] <= bus.ex_target;
                end else begin
                    m_cnt[i] <= (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (bus.ex_taken) begin
                m_valid[i]  <= 1'b1;
                m_tag[i]    <= m_tagof(bus.ex_pc);
                m_target[i] <= bus.ex_target;
                m_cnt[i]    <= 2;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pred_taken",  32'(bus.pred_taken), 32'(m_ptaken(bus.if_pc)));
            check("pred_target", bus.pred_target,     m_ptarget(bus.if_pc));
            check("mispredict",  32'(bus.mispredict), 32'(m_mispredict()));
            check("redirect_pc", bus.redirect_pc,     m_redirect());
            check("br_count",    bus.br_count,        m_br);
            check("mp_count",    bus.mp_count,        m_mp);
        end
    end

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                          input logic pt, input logic [31:0] ptg);
        bus.ex_valid       = v;
        bus.ex_pc          = pc;
        bus.ex_taken       = tk;
        bus.ex_target      = tg;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
    endtask

    task automatic idle();
        set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg);
        @(posedge clk);
        #1 set_ex(1'b1, pc, tk, tg, pt, ptg);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        idle();
        bus.if_pc = 32'h100;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_pred_taken",  32'(bus.pred_taken), 32'd0);
        check("rst_pred_target", bus.pred_target,     32'h104);
        check("rst_br_count",    bus.br_count,        32'd0);
        check("rst_mp_count",    bus.mp_count,        32'd0);

        // first taken resolution allocates
        @(posedge clk);
        #1 set_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        @(negedge clk);
        check("alloc_mispredict", 32'(bus.mispredict), 32'd1);
        check("alloc_redirect",   bus.redirect_pc,     32'h80);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        check("alloc_pred_taken",  32'(bus.pred_taken),         32'd1);
        check("alloc_pred_target", bus.pred_target,             32'h80);
        check("alloc_mp_count",    bus.mp_count,                32'd1);
        check("alloc_ctr",         32'(dut.u_array.ctr_q[0]),   32'h2);

        // saturation up and down
        for (int i = 0; i < 6; i++) begin
            resolve(32'h100, seq_taken[i], 32'h80, seq_pred[i], seq_pred[i] ? 32'h80 : 32'h104);
            check("seq_ctr",        32'(dut.u_array.ctr_q[0]), 32'(seq_ctr[i]));
            check("seq_pred_taken", 32'(bus.pred_taken),       32'(seq_after[i]));
        end

        // aliasing 0x100 / 0x140 on index 0
        resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check("alias_0x100_taken", 32'(bus.pred_taken), 32'd1);
        bus.if_pc = 32'h140;
        @(negedge clk);
        check("alias_0x140_taken",  32'(bus.pred_taken), 32'd0);
        check("alias_0x140_target", bus.pred_target,     32'h144);
        resolve(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        check("alias_0x140_target2", bus.pred_target, 32'h500);
        bus.if_pc = 32'h100;
        @(negedge clk);
        check("alias_0x100_evicted", 32'(bus.pred_taken), 32'd0);
        check("alias_0x100_target",  bus.pred_target,     32'h104);

        // same-cycle lookup and update
        @(posedge clk);
        #1 bus.if_pc = 32'h200;
        set_ex(1'b1, 32'h200, 1'b1, 32'h600, 1'b0, 32'h204);
        @(negedge clk);
        check("same_cycle_old", 32'(bus.pred_taken), 32'd0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        check("same_cycle_new",    32'(bus.pred_taken), 32'd1);
        check("same_cycle_target", bus.pred_target,     32'h600);

        // wrong target, then inactive EX with mismatching inputs
        @(posedge clk);
        #1 set_ex(1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h300);
        @(negedge clk);
        check("wrong_tgt_mispredict", 32'(bus.mispredict), 32'd1);
        check("wrong_tgt_redirect",   bus.redirect_pc,     32'h400);
        @(posedge clk);
        #1 set_ex(1'b0, 32'h200, 1'b1, 32'h700, 1'b0, 32'h204);
        @(negedge clk);
        check("novalid_mispredict", 32'(bus.mispredict), 32'd0);
        check("wrong_tgt_updated",  bus.pred_target,     32'h400);
        check("br_count_12",        bus.br_count,        32'd12);
        check("mp_count_8",         bus.mp_count,        32'd8);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        check("novalid_br_hold", bus.br_count, 32'd12);
        check("novalid_mp_hold", bus.mp_count, 32'd8);
        bus.if_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_pred_target", bus.pred_target, 32'h0);

        // reset in the middle of an update drops it
        @(posedge clk);
        #1 bus.if_pc = 32'h300;
        set_ex(1'b1, 32'h300, 1'b1, 32'h900, 1'b0, 32'h304);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        @(negedge clk);
        check("rst_mid_taken",  32'(bus.pred_taken), 32'd0);
        check("rst_mid_target", bus.pred_target,     32'h304);
        check("rst_mid_br",     bus.br_count,        32'd0);

        repeat (2000) begin
            @(posedge clk);
            #1;
            bus.if_pc = rand_pc();
            pc = rand_pc();
            tk = 1'($urandom_range(0, 1));
            tg = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
            if ($urandom_range(0, 3) != 0) begin
                set_ex(1'($urandom_range(0, 1)), pc, tk, tg, m_ptaken(pc), m_ptarget(pc));
            end else begin
                set_ex(1'($urandom_range(0, 1)), pc, tk, tg, 1'($urandom_range(0, 1)),
                       32'h1000 + 32'($urandom_range(0, 3)) * 32'd4);
            end
        end
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
